// File: rtl/framebuffer_queue.sv
// Queued framebuffer controller: bus writes go through a FIFO to an async SRAM, reads are ordered behind them.
// Optional FBQ_STATUS_EN adds the level/overflow status ports.
module framebuffer_queue #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       dataIn,
    input  logic [1:0]        byteEn,
    output logic              ready,
    output logic [15:0]       dataOut,
    output logic              readValid,
    output logic [ADDR_W-1:0] ADDRESS_PINS,
    output logic [15:0]       DATA_OUT_PINS,
    input  logic [15:0]       DATA_IN_PINS,
    output logic              DATA_DRIVE,
    output logic              CE,
    output logic              OE,
    output logic              WR,
    output logic              UB,
    output logic              LB
`ifdef FBQ_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`endif
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        be;
    } wr_entry_t;

    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_DONE} state_t;

    wr_entry_t         mem_q [DEPTH];
    logic [PW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    wr_entry_t         cur_q, cur_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_pend_q, rd_pend_d;

    logic              ce_q, ce_d, oe_q, oe_d, wr_q, wr_d, ub_q, ub_d, lb_q, lb_d;
    logic              drive_q, drive_d, rv_q, rv_d;
    logic [ADDR_W-1:0] apins_q, apins_d;
    logic [15:0]       dpins_q, dpins_d, dout_q, dout_d;

    logic empty, full, push, rd_acc, pop;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign ready  = !full && !rd_pend_q;
    assign push   = write && ready;
    assign rd_acc = read && ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        pop       = 1'b0;
        rd_pend_d = rd_pend_q | rd_acc;
        rd_addr_d = rd_acc ? address : rd_addr_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = W_SETUP;
                end else if (rd_pend_q) begin
                    cnt_d   = '0;
                    state_d = R_ACCESS;
                end
            end
            W_SETUP: begin
                cnt_d   = '0;
                state_d = W_PULSE;
            end
            W_PULSE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = W_HOLD;
            end
            W_HOLD: begin
                // Chain straight into the next queued write so each entry costs WAIT_CYCLES+2 clocks.
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = W_SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            R_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WAIT_CYCLES)) state_d = R_DONE;
            end
            R_DONE: begin
                rd_pend_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) cur_d = mem_q[rptr_q[PW-1:0]];
        wptr_d = wptr_q + (PW+1)'(push);
        rptr_d = rptr_q + (PW+1)'(pop);
    end

    // Pins follow the state one clock later, so every strobe comes straight from a flop.
    always_comb begin
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        wr_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        drive_d = 1'b0;
        rv_d    = 1'b0;
        apins_d = apins_q;
        dpins_d = dpins_q;
        dout_d  = dout_q;
        case (state_q)
            W_SETUP, W_PULSE, W_HOLD: begin
                ce_d    = 1'b0;
                wr_d    = (state_q != W_PULSE);
                ub_d    = ~cur_q.be[1];
                lb_d    = ~cur_q.be[0];
                drive_d = 1'b1;
                apins_d = cur_q.addr;
                dpins_d = cur_q.data;
            end
            R_ACCESS: begin
                ce_d    = 1'b0;
                oe_d    = 1'b0;
                ub_d    = 1'b0;
                lb_d    = 1'b0;
                apins_d = rd_addr_q;
            end
            R_DONE: begin
                rv_d   = 1'b1;
                dout_d = DATA_IN_PINS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= '{addr: address, data: dataIn, be: byteEn};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_q     <= '0;
            rd_addr_q <= '0;
            rd_pend_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            wr_q      <= 1'b1;
            ub_q      <= 1'b1;
            lb_q      <= 1'b1;
            drive_q   <= 1'b0;
            rv_q      <= 1'b0;
            apins_q   <= '0;
            dpins_q   <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            rd_addr_q <= rd_addr_d;
            rd_pend_q <= rd_pend_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ce_q      <= ce_d;
            oe_q      <= oe_d;
            wr_q      <= wr_d;
            ub_q      <= ub_d;
            lb_q      <= lb_d;
            drive_q   <= drive_d;
            rv_q      <= rv_d;
            apins_q   <= apins_d;
            dpins_q   <= dpins_d;
            dout_q    <= dout_d;
        end
    end

    assign CE            = ce_q;
    assign OE            = oe_q;
    assign WR            = wr_q;
    assign UB            = ub_q;
    assign LB            = lb_q;
    assign DATA_DRIVE    = drive_q;
    assign ADDRESS_PINS  = apins_q;
    assign DATA_OUT_PINS = dpins_q;
    assign readValid     = rv_q;
    assign dataOut       = dout_q;

`ifdef FBQ_STATUS_EN
    logic overflow_q, overflow_d;

    assign overflow_d = overflow_q | ((write | read) & ~ready);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign level    = wptr_q - rptr_q;
    assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_framebuffer_queue.sv
// Bench for framebuffer_queue: a cycle timeline model of the SRAM schedule for a WAIT_CYCLES=1
// instance, plus directed checks on a WAIT_CYCLES=3 instance.
`timescale 1ns/1ps
module tb_framebuffer_queue;
    localparam int D    = 16;
    localparam int W1   = 1;
    localparam int MAXC = 1024;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        wr1 = 0, rd1 = 0, wr3 = 0, rd3 = 0;
    logic [15:0] addr1 = 0, din1 = 0, addr3 = 0, din3 = 0;
    logic [1:0]  be1 = 0, be3 = 0;
    logic        ready1, rv1, dd1, ce1, oe1, we1, ub1, lb1;
    logic        ready3, rv3, dd3, ce3, oe3, we3, ub3, lb3;
    logic [15:0] dout1, ap1, dop1, dip1, dout3, ap3, dop3, dip3;
`ifdef FBQ_STATUS_EN
    logic [4:0]  level1, level3;
    logic        ovf1, ovf3;
`endif

    framebuffer_queue #(.ADDR_W(16), .DEPTH(D), .WAIT_CYCLES(W1)) dut1 (
        .CLK(CLK), .RST(RST), .write(wr1), .read(rd1), .address(addr1), .dataIn(din1),
        .byteEn(be1), .ready(ready1), .dataOut(dout1), .readValid(rv1), .ADDRESS_PINS(ap1),
        .DATA_OUT_PINS(dop1), .DATA_IN_PINS(dip1), .DATA_DRIVE(dd1), .CE(ce1), .OE(oe1),
        .WR(we1), .UB(ub1), .LB(lb1)
`ifdef FBQ_STATUS_EN
        , .level(level1), .overflow(ovf1)
`endif
    );

    framebuffer_queue #(.ADDR_W(16), .DEPTH(D), .WAIT_CYCLES(3)) dut3 (
        .CLK(CLK), .RST(RST), .write(wr3), .read(rd3), .address(addr3), .dataIn(din3),
        .byteEn(be3), .ready(ready3), .dataOut(dout3), .readValid(rv3), .ADDRESS_PINS(ap3),
        .DATA_OUT_PINS(dop3), .DATA_IN_PINS(dip3), .DATA_DRIVE(dd3), .CE(ce3), .OE(oe3),
        .WR(we3), .UB(ub3), .LB(lb3)
`ifdef FBQ_STATUS_EN
        , .level(level3), .overflow(ovf3)
`endif
    );

    // Async SRAMs: data is committed on the rising edge of WR while CE is low.
    logic [15:0] sram1 [0:65535];
    logic [15:0] sram3 [0:65535];
    assign dip1 = (!ce1 && !oe1) ? sram1[ap1] : 16'hDEAD;
    assign dip3 = (!ce3 && !oe3) ? sram3[ap3] : 16'hDEAD;
    always @(posedge we1) if (!RST && !ce1) begin
        if (!ub1) sram1[ap1][15:8] <= dop1[15:8];
        if (!lb1) sram1[ap1][7:0]  <= dop1[7:0];
    end
    always @(posedge we3) if (!RST && !ce3) begin
        if (!ub3) sram3[ap3][15:8] <= dop3[15:8];
        if (!lb3) sram3[ap3][7:0]  <= dop3[7:0];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: actual %h required %h", nm, cyc, act, exp);
    endtask

    // Timeline model: per-cycle expected pins derived from the scheduling rules.
    logic [5:0]  e_str  [MAXC];  // {CE,OE,WR,UB,LB,DATA_DRIVE}
    logic        e_act  [MAXC];
    logic        e_wact [MAXC];
    logic [15:0] e_addr [MAXC];
    logic [15:0] e_dout [MAXC];
    logic        e_rv   [MAXC];
    logic [15:0] e_rdat [MAXC];
    logic        e_pend [MAXC];
    int          e_push [MAXC];
    int          e_pop  [MAXC];
    logic [15:0] mmem   [0:65535];
    int          eng_free = 0;
    bit          model_on = 0;
    int          acc_w = 0;

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            e_str[i] = 6'b111110; e_act[i] = 0; e_wact[i] = 0; e_addr[i] = 0; e_dout[i] = 0;
            e_rv[i] = 0; e_rdat[i] = 0; e_pend[i] = 0; e_push[i] = 0; e_pop[i] = 0;
        end
        eng_free = 0;
    endtask

    function automatic logic m_ready(input int k);
        int c = 0;
        for (int i = 0; i <= k && i < MAXC; i++) c += e_push[i] - e_pop[i];
        return !e_pend[k] && (c < D);
    endfunction

    task automatic m_write(input int t, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        int s;
        s = (t + 2 > eng_free) ? t + 2 : eng_free;
        for (int i = s; i <= s + W1 + 1 && i < MAXC; i++) begin
            e_str[i]  = {1'b0, 1'b1, !(i > s && i <= s + W1), ~be[1], ~be[0], 1'b1};
            e_act[i]  = 1; e_wact[i] = 1; e_addr[i] = a; e_dout[i] = d;
        end
        eng_free = s + W1 + 2;
        e_push[t]++;
        e_pop[s-1]++;
        if (be[1]) mmem[a][15:8] = d[15:8];
        if (be[0]) mmem[a][7:0]  = d[7:0];
    endtask

    task automatic m_read(input int t, input logic [15:0] a);
        int s;
        s = (t + 2 > eng_free + 1) ? t + 2 : eng_free + 1;
        for (int i = s; i <= s + W1 && i < MAXC; i++) begin
            e_str[i] = 6'b001000; e_act[i] = 1; e_addr[i] = a;
        end
        for (int i = t; i <= s + W1 && i < MAXC; i++) e_pend[i] = 1;
        e_rv[s+W1+1]   = 1;
        e_rdat[s+W1+1] = mmem[a];
        eng_free = s + W1 + 2;
    endtask

    always @(posedge CLK) begin
        #2;
        if (model_on && cyc < MAXC) begin
            chk("pins_strobes_ready", {ce1, oe1, we1, ub1, lb1, dd1, rv1, ready1},
                {e_str[cyc], e_rv[cyc], m_ready(cyc)});
            if (e_act[cyc])  chk("address_pins", ap1, e_addr[cyc]);
            if (e_wact[cyc]) chk("data_out_pins", dop1, e_dout[cyc]);
            if (e_rv[cyc])   chk("read_data", dout1, e_rdat[cyc]);
        end
    end

    // Drive one request for the next edge; t is that edge's cycle number.
    task automatic bus(input int sel, input logic w, input logic r, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be, output int t);
        @(negedge CLK);
        t = cyc + 1;
        if (sel == 0) begin
            wr1 = w; rd1 = r; addr1 = a; din1 = d; be1 = be;
            if (model_on && m_ready(cyc)) begin
                if (w) begin m_write(t, a, d, be); acc_w++; end
                if (r) m_read(t, a);
            end
        end else begin
            wr3 = w; rd3 = r; addr3 = a; din3 = d; be3 = be;
        end
    endtask

    task automatic watch(input int sel, input int n, output int ce_first, output int oe_first,
                         output int wr_lo, output int oe_lo, output int rv_cnt, output int rv_cyc,
                         output logic [15:0] rv_dat, output logic [33:0] ce_pins);
        ce_first = -1; oe_first = -1; wr_lo = 0; oe_lo = 0; rv_cnt = 0; rv_cyc = -1;
        rv_dat = 0; ce_pins = 0;
        repeat (n) begin
            @(negedge CLK);
            if (sel == 0) begin wr1 = 0; rd1 = 0; end else begin wr3 = 0; rd3 = 0; end
            if (((sel == 0) ? ce1 : ce3) == 1'b0 && ce_first < 0) begin
                ce_first = cyc;
                ce_pins = (sel == 0) ? {ub1, lb1, ap1, dop1} : {ub3, lb3, ap3, dop3};
            end
            if (((sel == 0) ? oe1 : oe3) == 1'b0) begin
                oe_lo++;
                if (oe_first < 0) oe_first = cyc;
            end
            if (((sel == 0) ? we1 : we3) == 1'b0) wr_lo++;
            if (((sel == 0) ? rv1 : rv3) == 1'b1) begin
                rv_cnt++; rv_cyc = cyc; rv_dat = (sel == 0) ? dout1 : dout3;
            end
        end
    endtask

    initial begin
        int t, t0, a_before, cef, oef, wrl, oel, rvc, rvy;
        logic [15:0] rvd;
        logic [33:0] cep;
        for (int i = 0; i < 65536; i++) begin sram1[i] = 0; sram3[i] = 0; mmem[i] = 0; end
        model_clear();
        repeat (3) @(negedge CLK);
        chk("reset_ctrl_1", {ready1, rv1, dd1, ce1, oe1, we1, ub1, lb1}, 8'b1001_1111);
        chk("reset_data_1", {ap1, dop1}, 0);
        chk("reset_dout_1", dout1, 0);
        chk("reset_ctrl_3", {ready3, rv3, dd3, ce3, oe3, we3, ub3, lb3}, 8'b1001_1111);
`ifdef FBQ_STATUS_EN
        chk("reset_status", {level1, ovf1}, 0);
`endif
        RST = 1'b0;
        model_on = 1;

        // Single write: CE low two clocks after acceptance, one WR-low clock.
        bus(0, 1, 0, 16'h0010, 16'hBEEF, 2'b11, t);
        watch(0, 12, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("write_ce_latency", cef - t, 2);
        chk("write_wr_low_clks", wrl, 1);
        chk("write_pins", cep, {2'b00, 16'h0010, 16'hBEEF});

        // Write then read next cycle: read waits for the write to finish.
        bus(0, 1, 0, 16'h0020, 16'h1234, 2'b11, t0);
        bus(0, 0, 1, 16'h0020, 16'h0000, 2'b00, t);
        watch(0, 16, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("raw_oe_start", oef - t0, 6);
        chk("raw_valid_cycle", rvy - t0, 8);
        chk("raw_data", rvd, 16'h1234);
        chk("raw_pulses", rvc, 1);

        // Write and read in the same cycle.
        bus(0, 1, 1, 16'h0024, 16'h4321, 2'b11, t0);
        watch(0, 16, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("same_cycle_valid", rvy - t0, 8);
        chk("same_cycle_data", rvd, 16'h4321);

        // Back-to-back writes until full: 24 fit while draining, the 25th is dropped.
        a_before = acc_w;
        for (int i = 0; i < 25; i++) begin
            bus(0, 1, 0, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 2'b11, t);
            if (i == 0) t0 = t;
            if (i == 24) begin
                chk("fill_ready_low", {31'd0, ready1}, 0);
`ifdef FBQ_STATUS_EN
                chk("fill_level", level1, 16);
`endif
            end
        end
        chk("fill_accepted", acc_w - a_before, 24);
        watch(0, 90, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("fill_last_in_sram", sram1[16'h0117], 16'hC017);
        chk("fill_dropped_absent", sram1[16'h0118], 16'h0000);
`ifdef FBQ_STATUS_EN
        chk("fill_overflow", ovf1, 1);
`endif

        // Byte lanes: be=01 merges the low byte, be=00 writes nothing.
        bus(0, 1, 0, 16'h0030, 16'hFFFF, 2'b11, t);
        bus(0, 1, 0, 16'h0030, 16'hAA55, 2'b01, t);
        bus(0, 1, 0, 16'h0030, 16'h0000, 2'b00, t);
        bus(0, 0, 1, 16'h0030, 16'h0000, 2'b00, t);
        watch(0, 24, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("byte_read", rvd, 16'hFF55);
        chk("byte_sram", sram1[16'h0030], 16'hFF55);

        // Reset in the middle of a WR pulse with more writes queued.
        model_on = 0;
        bus(0, 1, 0, 16'h0040, 16'h1111, 2'b11, t0);
        bus(0, 1, 0, 16'h0041, 16'h2222, 2'b11, t);
        bus(0, 1, 0, 16'h0042, 16'h3333, 2'b11, t);
        bus(0, 1, 0, 16'h0043, 16'h4444, 2'b11, t);
        @(posedge CLK);
        #2;
        chk("rst_in_pulse", {ce1, we1}, 2'b00);
        RST = 1'b1;
        wr1 = 0;
        #1;
        chk("rst_async_strobes", {ce1, we1, dd1}, 3'b110);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        watch(0, 20, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("rst_no_more_cycles", cef, -1);
        chk("rst_ready", ready1, 1);
`ifdef FBQ_STATUS_EN
        chk("rst_level", level1, 0);
        chk("rst_overflow_cleared", ovf1, 0);
`endif
        model_clear();
        model_on = 1;
        bus(0, 1, 0, 16'h0050, 16'h7777, 2'b11, t);
        bus(0, 0, 1, 16'h0050, 16'h0000, 2'b00, t);
        watch(0, 16, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("post_rst_read", rvd, 16'h7777);

        // WAIT_CYCLES=3 instance.
        bus(1, 1, 0, 16'h0060, 16'h5A5A, 2'b11, t);
        watch(1, 12, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("w3_ce_latency", cef - t, 2);
        chk("w3_wr_low_clks", wrl, 3);
        bus(1, 0, 1, 16'h0060, 16'h0000, 2'b00, t);
        watch(1, 12, cef, oef, wrl, oel, rvc, rvy, rvd, cep);
        chk("w3_oe_low_clks", oel, 4);
        chk("w3_oe_start", oef - t, 2);
        chk("w3_valid_cycle", rvy - t, 6);
        chk("w3_read_data", rvd, 16'h5A5A);
        chk("w3_pulses", rvc, 1);

        model_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
